// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared constants and helpers for the time-of-day core.
//   SEC_W/MIN_W/HOUR_W   : field widths of the sec/min/hour registers
//   SEC_MAX/MIN_MAX/HOUR_MAX : last legal value of each field
//   to_12h()             : maps a 24 h hour (0..23) to its 12 h display form (1..12)
package rtc_pkg;

   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   // 0 -> 12 (midnight), 13..23 -> 1..11, everything else unchanged
   function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
      logic [HOUR_W-1:0] r;
      if (h == '0)
         r = 5'd12;
      else if (h > 5'd12)
         r = h - 5'd12;
      else
         r = h;
      return r;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter
// Loadable modulo-(MAX+1) counter used for each time field.
//   clock  : system clock, posedge
//   reset  : synchronous, active-low
//   inc    : advance by one, wrapping MAX -> 0
//   ld     : write ld_val (takes priority over inc)
//   ld_val : value to load
//   q      : current count
//   carry  : combinational; high when inc is applied while q == MAX
module mod_counter #(
   parameter int unsigned     W   = 6,
   parameter logic [W-1:0]    MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] q,
   output logic         carry
);

   assign carry = inc && (q == MAX);

   always_ff @(posedge clock) begin
      if (!reset)
         q <= '0;
      else if (ld)
         q <= ld_val;
      else if (inc)
         q <= (q == MAX) ? '0 : q + W'(1);
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper
// Time-of-day core with 1 Hz prescaler, range-checked loads, hh:mm alarm and 12/24 h view.
//   clock, reset          : system clock (posedge), synchronous active-low reset
//   enable                : 1 = prescaler and time run, 0 = hold
//   load_sec/min/hour     : write data_sec/min/hour (out-of-range values rejected)
//   data_sec/min/hour     : load values (hour in 24 h form)
//   alarm_load            : latch alarm_min/alarm_hour
//   alarm_min/alarm_hour  : alarm time (24 h form, no range check)
//   alarm_en              : alarm armed
//   mode_12h              : select 12 h form for disp_hour
//   sec/min/hour          : current time
//   disp_hour, pm         : display hour and afternoon flag
//   tick_1hz              : pulse, time advanced on the previous edge
//   day_wrap              : pulse, 23:59:59 -> 00:00:00 occurred
//   alarm_hit             : pulse, new time equals alarm_hour:alarm_min:00
//   load_err              : pulse, a load carried an out-of-range value
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              load_sec,
   input  logic              load_min,
   input  logic              load_hour,
   input  logic [SEC_W-1:0]  data_sec,
   input  logic [MIN_W-1:0]  data_min,
   input  logic [HOUR_W-1:0] data_hour,
   input  logic              alarm_load,
   input  logic [MIN_W-1:0]  alarm_min,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic              alarm_en,
   input  logic              mode_12h,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic [HOUR_W-1:0] disp_hour,
   output logic              pm,
   output logic              tick_1hz,
   output logic              day_wrap,
   output logic              alarm_hit,
   output logic              load_err
);

   logic [DIV_W-1:0]  prescaler;
   logic [MIN_W-1:0]  al_min;
   logic [HOUR_W-1:0] al_hour;

   logic any_load, at_top, advance;
   logic sec_ok, min_ok, hour_ok, bad_load;
   logic sec_carry, min_carry, hour_carry;
   logic [MIN_W-1:0]  nxt_min;
   logic [HOUR_W-1:0] nxt_hour;
   logic alarm_match;

   assign any_load = load_sec || load_min || load_hour;
   assign at_top   = (prescaler == DIV_W'(TICK_DIV - 1));
   // A load cycle owns the time registers, so it also swallows a coinciding tick
   assign advance  = enable && at_top && !any_load;

   assign sec_ok   = (data_sec  <= SEC_MAX);
   assign min_ok   = (data_min  <= MIN_MAX);
   assign hour_ok  = (data_hour <= HOUR_MAX);
   assign bad_load = (load_sec && !sec_ok) || (load_min && !min_ok) || (load_hour && !hour_ok);

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clock(clock), .reset(reset), .inc(advance), .ld(load_sec && sec_ok),
      .ld_val(data_sec), .q(sec), .carry(sec_carry)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clock(clock), .reset(reset), .inc(sec_carry), .ld(load_min && min_ok),
      .ld_val(data_min), .q(min), .carry(min_carry)
   );

   mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
      .clock(clock), .reset(reset), .inc(min_carry), .ld(load_hour && hour_ok),
      .ld_val(data_hour), .q(hour), .carry(hour_carry)
   );

   // Alarm time always has sec == 0, so a match is only possible on a seconds carry;
   // compare against the minute/hour values the counters are about to take.
   always_comb begin
      nxt_min  = min;
      nxt_hour = hour;
      if (sec_carry)
         nxt_min = min_carry ? '0 : min + MIN_W'(1);
      if (min_carry)
         nxt_hour = hour_carry ? '0 : hour + HOUR_W'(1);
      alarm_match = alarm_en && sec_carry && (nxt_min == al_min) && (nxt_hour == al_hour);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         prescaler <= '0;
         al_min    <= '0;
         al_hour   <= '0;
         tick_1hz  <= 1'b0;
         day_wrap  <= 1'b0;
         alarm_hit <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         if (any_load)
            prescaler <= '0;
         else if (enable)
            prescaler <= at_top ? '0 : prescaler + DIV_W'(1);

         if (alarm_load) begin
            al_min  <= alarm_min;
            al_hour <= alarm_hour;
         end

         tick_1hz  <= advance;
         day_wrap  <= hour_carry;
         alarm_hit <= alarm_match;
         load_err  <= bad_load;
      end
   end

   assign disp_hour = mode_12h ? to_12h(hour) : hour;
   assign pm        = (hour >= 5'd12);

endmodule
